uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx_controller.sv | 134 +++++++++++++
 tb/tb_uart_rx_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Holds the receiver FSM state encoding and frame geometry defaults.
package uart_pkg;

  localparam int WORD_SIZE_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous RX line.
// Flops reset to 1 so the line looks idle while leaving reset.
module uart_sync2 (
  input  logic Clock,
  input  logic Reset,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta <= 1'b1;
      Q    <= 1'b1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// Oversampled UART receiver with a single holding register,
// sticky framing/overrun status and a consumer acknowledge.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 SampleTick,
  input  logic                 SerialIn,
  input  logic                 ClearFlag,
  output logic [WORD_SIZE-1:0] DataOut,
  output logic                 Flag,
  output logic                 FramingError,
  output logic                 OverrunError,
  output logic                 Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_SIZE + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_SIZE - 1);

  rx_state_t             state, stateNext;
  logic [CW-1:0]         sampleCnt, sampleCntNext;
  logic [BW-1:0]         bitCnt, bitCntNext;
  logic [WORD_SIZE-1:0]  shiftReg, shiftNext;
  logic                  loadGood, loadBad;
  logic                  rxS;

  uart_sync2 uSync (
    .Clock (Clock),
    .Reset (Reset),
    .D     (SerialIn),
    .Q     (rxS)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
    end else begin
      state     <= stateNext;
      sampleCnt <= sampleCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
    end
  end

  // Everything moves only on ticks, so RxS between sample points is ignored.
  always_comb begin
    stateNext     = state;
    sampleCntNext = sampleCnt;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    loadGood      = 1'b0;
    loadBad       = 1'b0;
    if (SampleTick) begin
      unique case (state)
        IDLE: begin
          if (!rxS) begin
            stateNext     = START;
            sampleCntNext = '0;
          end
        end
        START: begin
          if (sampleCnt == HALF_LAST) begin
            sampleCntNext = '0;
            bitCntNext    = '0;
            stateNext     = rxS ? IDLE : DATA;
          end else begin
            sampleCntNext = sampleCnt + CW'(1);
          end
        end
        DATA: begin
          if (sampleCnt == FULL_LAST) begin
            sampleCntNext = '0;
            shiftNext     = {rxS, shiftReg[WORD_SIZE-1:1]};
            bitCntNext    = bitCnt + BW'(1);
            if (bitCnt == LAST_BIT) begin
              stateNext = STOP;
            end
          end else begin
            sampleCntNext = sampleCnt + CW'(1);
          end
        end
        STOP: begin
          if (sampleCnt == FULL_LAST) begin
            sampleCntNext = '0;
            stateNext     = IDLE;
            loadGood      = rxS;
            loadBad       = !rxS;
          end else begin
            sampleCntNext = sampleCnt + CW'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // A load beats a simultaneous acknowledge; the acknowledge
  // then only suppresses the overrun it would have caused.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      DataOut      <= '0;
      Flag         <= 1'b0;
      FramingError <= 1'b0;
      OverrunError <= 1'b0;
    end else if (loadGood) begin
      DataOut      <= shiftReg;
      Flag         <= 1'b1;
      FramingError <= 1'b0;
      OverrunError <= Flag & ~ClearFlag;
    end else begin
      if (ClearFlag) begin
        Flag         <= 1'b0;
        OverrunError <= 1'b0;
      end
      if (loadBad) begin
        FramingError <= 1'b1;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Frame-level bench for uart_rx_controller: random and directed
// frames checked against a holding-register model.
module tb_uart_rx_controller;

  localparam int OS = 16;
  localparam int WS = 8;

  logic          Clock;
  logic          Reset;
  logic          SampleTick;
  logic          SerialIn;
  logic          ClearFlag;
  logic [WS-1:0] DataOut;
  logic          Flag;
  logic          FramingError;
  logic          OverrunError;
  logic          Busy;

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;
  int tickPeriod = 1;

  logic [WS-1:0] mData;
  logic          mFlag;
  logic          mFe;
  logic          mOvr;

  uart_rx_controller #(
    .WORD_SIZE  (WS),
    .OVERSAMPLE (OS)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .SampleTick   (SampleTick),
    .SerialIn     (SerialIn),
    .ClearFlag    (ClearFlag),
    .DataOut      (DataOut),
    .Flag         (Flag),
    .FramingError (FramingError),
    .OverrunError (OverrunError),
    .Busy         (Busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial forever @(posedge Clock) edgeCnt++;

  // Ticks land on edges whose index is a multiple of tickPeriod.
  initial begin
    SampleTick = 1'b0;
    forever begin
      @(negedge Clock);
      SampleTick = ((edgeCnt + 1) % tickPeriod == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".data"}, 32'(DataOut), 32'(mData));
    chk({tag, ".flag"}, 32'(Flag), 32'(mFlag));
    chk({tag, ".fe"}, 32'(FramingError), 32'(mFe));
    chk({tag, ".ovr"}, 32'(OverrunError), 32'(mOvr));
    chk({tag, ".busy"}, 32'(Busy), 32'd0);
  endtask

  task automatic modelReset();
    mData = '0;
    mFlag = 1'b0;
    mFe   = 1'b0;
    mOvr  = 1'b0;
  endtask

  task automatic modelFrame(input logic [WS-1:0] d, input logic stopOk,
                            input logic ackAtLoad);
    if (stopOk) begin
      mOvr  = ackAtLoad ? 1'b0 : (mFlag | mOvr);
      mFlag = 1'b1;
      mData = d;
      mFe   = 1'b0;
    end else begin
      mFe = 1'b1;
    end
  endtask

  task automatic waitTicks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge Clock);
      if (SampleTick) k++;
    end
    @(negedge Clock);
  endtask

  task automatic ackPulse();
    ClearFlag = 1'b1;
    @(negedge Clock);
    ClearFlag = 1'b0;
    mFlag = 1'b0;
    mOvr  = 1'b0;
  endtask

  // mode 0: plain, 1: ClearFlag in the load cycle, 2: check Flag edge.
  task automatic sendFrame(input logic [WS-1:0] d, input logic stopBit,
                           input int mode);
    int e0;
    int det;
    int ld;
    SerialIn = 1'b0;
    e0  = edgeCnt + 1;
    det = e0 + 2;
    while (det % tickPeriod != 0) det++;
    ld = det + (OS / 2 + OS * WS + OS) * tickPeriod;
    fork
      begin
        waitTicks(OS);
        for (int i = 0; i < WS; i++) begin
          SerialIn = d[i];
          waitTicks(OS);
        end
        SerialIn = stopBit;
        waitTicks(OS);
        SerialIn = 1'b1;
      end
      if (mode != 0) begin
        while (edgeCnt != ld - 1) @(negedge Clock);
        if (mode == 1) ClearFlag = 1'b1;
        else chk("flagBeforeLoad", 32'(Flag), 32'd0);
        @(negedge Clock);
        if (mode == 1) ClearFlag = 1'b0;
        else chk("flagAtLoad", 32'(Flag), 32'd1);
      end
    join
    if (!stopBit) waitTicks(2 * OS);
    else waitTicks(2);
  endtask

  initial begin
    logic [WS-1:0] d;
    logic          ok;
    logic          ack;
    logic [WS-1:0] partial;

    tickPeriod = $urandom_range(1, 3);
    Reset      = 1'b1;
    SerialIn   = 1'b1;
    ClearFlag  = 1'b0;
    modelReset();
    repeat (3) @(negedge Clock);
    checkAll("inReset");
    Reset = 1'b0;
    waitTicks(OS);
    checkAll("afterRelease");

    sendFrame(8'hA5, 1'b1, 2);
    modelFrame(8'hA5, 1'b1, 1'b0);
    checkAll("frameA5");
    ackPulse();
    checkAll("ackA5");

    SerialIn = 1'b0;
    waitTicks(4);
    chk("glitchBusy", 32'(Busy), 32'd1);
    SerialIn = 1'b1;
    waitTicks(2 * OS);
    checkAll("glitch");

    sendFrame(8'h3C, 1'b0, 0);
    modelFrame(8'h3C, 1'b0, 1'b0);
    checkAll("badStop3C");
    sendFrame(8'h55, 1'b1, 0);
    modelFrame(8'h55, 1'b1, 1'b0);
    checkAll("good55");
    ackPulse();

    sendFrame(8'h11, 1'b1, 0);
    modelFrame(8'h11, 1'b1, 1'b0);
    checkAll("first11");
    sendFrame(8'h22, 1'b1, 0);
    modelFrame(8'h22, 1'b1, 1'b0);
    checkAll("overrun22");
    ackPulse();
    checkAll("ackOverrun");

    sendFrame(8'h99, 1'b1, 0);
    modelFrame(8'h99, 1'b1, 1'b0);
    sendFrame(8'h7E, 1'b1, 1);
    modelFrame(8'h7E, 1'b1, 1'b1);
    checkAll("ackAtLoad7E");

    partial  = 8'hF0;
    SerialIn = 1'b0;
    waitTicks(OS);
    for (int i = 0; i < 3; i++) begin
      SerialIn = partial[i];
      waitTicks(OS);
    end
    SerialIn = partial[3];
    waitTicks(OS / 2);
    chk("midFrameBusy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    modelReset();
    checkAll("asyncReset");
    @(negedge Clock);
    SerialIn = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    waitTicks(OS);
    sendFrame(8'h81, 1'b1, 0);
    modelFrame(8'h81, 1'b1, 1'b0);
    checkAll("after reset 81");

    for (int n = 0; n < 30; n++) begin
      d   = WS'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      ack = ($urandom_range(0, 2) == 0);
      if (ack) ackPulse();
      sendFrame(d, ok, 0);
      modelFrame(d, ok, 1'b0);
      checkAll($sformatf("rnd%0d", n));
      waitTicks($urandom_range(1, OS));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
